// File: rtl/hpm_det_pkg.sv
// hpm_det_pkg
// Shared types and constants for the HPM decision-tree attack detector.
//   hpm_class_e : classification result driven on alert_o / stored per leaf
//   cfg_sel_e   : meaning of cfg_sel_i on the configuration port
//   det_state_e : walk controller states
//   DEF_THR_*   : thresholds that reproduce the legacy two-level detector
package hpm_det_pkg;

  typedef enum logic [1:0] {
    CLS_LEG  = 2'b00,
    CLS_RSVD = 2'b01,
    CLS_SBO  = 2'b10,
    CLS_HBO  = 2'b11
  } hpm_class_e;

  typedef enum logic [1:0] {
    SEL_THR  = 2'b00,
    SEL_FEAT = 2'b01,
    SEL_LEAF = 2'b10,
    SEL_RSVD = 2'b11
  } cfg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WALK = 2'b01,
    ST_DONE = 2'b10
  } det_state_e;

  // Legacy detector: root compares counter 1 against 15, right child
  // compares counter 0 against 9, left child always goes left.
  localparam int LEGACY_DEPTH  = 2;
  localparam int DEF_THR_ROOT  = 15;
  localparam int DEF_THR_RIGHT = 9;

endpackage

// File: rtl/hpm_det_cfg_regs.sv
// hpm_det_cfg_regs
// Runtime-programmable register file for the decision tree: one threshold
// and one feature index per internal node, one class per leaf.
// Ports:
//   clk_h, rst_h      clock, asynchronous active-high reset (loads defaults)
//   cfg_we            write strobe
//   cfg_sel           target array (threshold / feature / leaf class)
//   cfg_addr          node or leaf index
//   cfg_wdata         write data (LSBs for feature and class)
//   busy              walk in progress; writes are dropped while high
//   rd_node           node being evaluated -> rd_thr, rd_feat
//   rd_leaf           leaf being reached   -> rd_class
module hpm_det_cfg_regs
  import hpm_det_pkg::*;
#(
  parameter int NUM_HPM = 4,
  parameter int CNT_W   = 32,
  parameter int DEPTH   = 2,
  parameter int FSEL_W  = $clog2(NUM_HPM),
  parameter int NODE_W  = DEPTH + 1
) (
  input  logic              clk_h,
  input  logic              rst_h,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [7:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic              busy,
  input  logic [NODE_W-1:0] rd_node,
  output logic [CNT_W-1:0]  rd_thr,
  output logic [FSEL_W-1:0] rd_feat,
  input  logic [NODE_W-1:0] rd_leaf,
  output hpm_class_e        rd_class
);

  localparam int NODES  = (1 << DEPTH) - 1;
  localparam int LEAVES = 1 << DEPTH;

  logic [CNT_W-1:0]  thr      [NODES];
  logic [FSEL_W-1:0] feat     [NODES];
  hpm_class_e        leaf_cls [LEAVES];

  logic              wr_ok;
  logic [FSEL_W-1:0] feat_wr;

  // Only the legacy depth has a meaningful preset tree; any other depth
  // starts as "everything is legitimate" until software programs it.
  function automatic logic [CNT_W-1:0] def_thr(input int idx);
    if (DEPTH == LEGACY_DEPTH && idx == 0) return CNT_W'(DEF_THR_ROOT);
    if (DEPTH == LEGACY_DEPTH && idx == 2) return CNT_W'(DEF_THR_RIGHT);
    return '1;
  endfunction

  function automatic logic [FSEL_W-1:0] def_feat(input int idx);
    if (DEPTH == LEGACY_DEPTH && idx == 0) return FSEL_W'(1);
    return '0;
  endfunction

  function automatic hpm_class_e def_class(input int idx);
    if (DEPTH == LEGACY_DEPTH && idx == 2) return CLS_SBO;
    if (DEPTH == LEGACY_DEPTH && idx == 3) return CLS_HBO;
    return CLS_LEG;
  endfunction

  assign wr_ok = cfg_we && !busy;

  // A feature index past the last counter would select nothing, so it is
  // pinned to the highest real counter instead.
  always_comb begin
    feat_wr = cfg_wdata[FSEL_W-1:0];
    if (cfg_wdata >= CNT_W'(NUM_HPM)) feat_wr = FSEL_W'(NUM_HPM - 1);
  end

  // Register file update. Addresses are matched entry by entry, so an
  // out-of-range index simply hits no entry and the write disappears.
  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      for (int i = 0; i < NODES; i++) begin
        thr[i]  <= def_thr(i);
        feat[i] <= def_feat(i);
      end
      for (int i = 0; i < LEAVES; i++) leaf_cls[i] <= def_class(i);
    end else if (wr_ok) begin
      case (cfg_sel_e'(cfg_sel))
        SEL_THR: begin
          for (int i = 0; i < NODES; i++)
            if (cfg_addr == 8'(i)) thr[i] <= cfg_wdata;
        end
        SEL_FEAT: begin
          for (int i = 0; i < NODES; i++)
            if (cfg_addr == 8'(i)) feat[i] <= feat_wr;
        end
        SEL_LEAF: begin
          for (int i = 0; i < LEAVES; i++)
            if (cfg_addr == 8'(i)) leaf_cls[i] <= hpm_class_e'(cfg_wdata[1:0]);
        end
        default: ;
      endcase
    end
  end

  // Read ports for the node currently being evaluated and the leaf it leads to.
  always_comb begin
    rd_thr  = '1;
    rd_feat = '0;
    for (int i = 0; i < NODES; i++) begin
      if (rd_node == NODE_W'(i)) begin
        rd_thr  = thr[i];
        rd_feat = feat[i];
      end
    end
  end

  always_comb begin
    rd_class = CLS_LEG;
    for (int i = 0; i < LEAVES; i++)
      if (rd_leaf == NODE_W'(i)) rd_class = leaf_cls[i];
  end

endmodule

// File: rtl/hpm_tree_detector.sv
// hpm_tree_detector
// Walks a programmable binary decision tree, one level per cycle, over a
// snapshot of the HPM counters and classifies the window as legitimate,
// stack overflow or heap overflow. Keeps a saturating count of alerts.
// Ports:
//   clk_h, rst_h     clock, asynchronous active-high reset
//   hpm_i            counter values (snapshotted on an accepted start)
//   start_i          classification request, honoured only when idle
//   busy_o           walk in progress (WALK and DONE cycles)
//   done_o           one-cycle pulse; alert_o is valid during it
//   alert_o          class of the most recent decision, held
//   alert_cnt_o      saturating count of non-legitimate decisions
//   cnt_clr_i        synchronous clear of alert_cnt_o, beats an increment
//   cfg_*            tree configuration port (ignored while busy)
module hpm_tree_detector
  import hpm_det_pkg::*;
#(
  parameter int NUM_HPM = 4,
  parameter int CNT_W   = 32,
  parameter int DEPTH   = 2,
  parameter int FSEL_W  = $clog2(NUM_HPM)
) (
  input  logic                            clk_h,
  input  logic                            rst_h,
  input  logic [NUM_HPM-1:0][CNT_W-1:0]   hpm_i,
  input  logic                            start_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [1:0]                      alert_o,
  output logic [CNT_W-1:0]                alert_cnt_o,
  input  logic                            cnt_clr_i,
  input  logic                            cfg_we_i,
  input  logic [1:0]                      cfg_sel_i,
  input  logic [7:0]                      cfg_addr_i,
  input  logic [CNT_W-1:0]                cfg_wdata_i
);

  localparam int NODES  = (1 << DEPTH) - 1;
  localparam int NODE_W = DEPTH + 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  det_state_e                    state, state_nxt;
  logic [NUM_HPM-1:0][CNT_W-1:0] snap;
  logic [NODE_W-1:0]             node, child, leaf;
  logic [LVL_W-1:0]              level;
  logic                          last_level;
  logic [CNT_W-1:0]              cur_thr, feat_val, alert_cnt;
  logic [FSEL_W-1:0]             cur_feat;
  hpm_class_e                    leaf_class, alert_q;

  hpm_det_cfg_regs #(
    .NUM_HPM (NUM_HPM),
    .CNT_W   (CNT_W),
    .DEPTH   (DEPTH),
    .FSEL_W  (FSEL_W),
    .NODE_W  (NODE_W)
  ) u_cfg (
    .clk_h     (clk_h),
    .rst_h     (rst_h),
    .cfg_we    (cfg_we_i),
    .cfg_sel   (cfg_sel_i),
    .cfg_addr  (cfg_addr_i),
    .cfg_wdata (cfg_wdata_i),
    .busy      (busy_o),
    .rd_node   (node),
    .rd_thr    (cur_thr),
    .rd_feat   (cur_feat),
    .rd_leaf   (leaf),
    .rd_class  (leaf_class)
  );

  // Feature mux: pick the snapshotted counter the current node looks at.
  always_comb begin
    feat_val = '0;
    for (int i = 0; i < NUM_HPM; i++)
      if (cur_feat == FSEL_W'(i)) feat_val = snap[i];
  end

  // Heap-ordered tree: children of n are 2n+1 (<= threshold) and 2n+2.
  // Leaves follow the internal nodes, so subtracting the node count
  // turns the final child index into a leaf index.
  assign child      = {node[NODE_W-2:0], 1'b0} +
                      ((feat_val <= cur_thr) ? NODE_W'(1) : NODE_W'(2));
  assign leaf       = child - NODE_W'(NODES);
  assign last_level = (level == LVL_W'(DEPTH - 1));

  // Walk controller state register.
  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs. start_i is only looked at in IDLE,
  // so requests during a walk or its DONE cycle are dropped, not queued.
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      ST_IDLE: if (start_i) state_nxt = ST_WALK;
      ST_WALK: begin
        busy_o = 1'b1;
        if (last_level) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot, tree position and result. The class is captured on the last
  // evaluation so it is already on alert_o while done_o is high.
  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      snap    <= '0;
      node    <= '0;
      level   <= '0;
      alert_q <= CLS_LEG;
    end else begin
      if (state == ST_IDLE && start_i) begin
        snap  <= hpm_i;
        node  <= '0;
        level <= '0;
      end else if (state == ST_WALK) begin
        node  <= child;
        level <= level + LVL_W'(1);
        if (last_level) alert_q <= leaf_class;
      end
    end
  end

  // Alert counter: bumps as DONE ends, saturates, and loses to a clear.
  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      alert_cnt <= '0;
    end else if (cnt_clr_i) begin
      alert_cnt <= '0;
    end else if (state == ST_DONE && alert_q != CLS_LEG && alert_cnt != '1) begin
      alert_cnt <= alert_cnt + CNT_W'(1);
    end
  end

  assign alert_o     = alert_q;
  assign alert_cnt_o = alert_cnt;

endmodule

// File: tb/tb_hpm_tree_detector.sv
// tb_hpm_tree_detector
// Three detector instances share one clock and reset:
//   dut_a : defaults (legacy tree, DEPTH=2, 32-bit counters)
//   dut_b : DEPTH=3, programmed at runtime
//   dut_c : CNT_W=4, used to reach counter saturation quickly
// Expected results are queued when a walk is launched and popped when
// the matching done_o pulse is seen.
module tb_hpm_tree_detector;

  logic clk_h = 1'b0;
  logic rst_h;
  always #5 clk_h = ~clk_h;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  cls;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  // dut_a signals
  logic [3:0][31:0] hpm_a;
  logic start_a, busy_a, done_a, cnt_clr_a, cfg_we_a;
  logic [1:0] alert_a, cfg_sel_a;
  logic [31:0] cnt_a, cfg_wdata_a;
  logic [7:0] cfg_addr_a;

  // dut_b signals
  logic [3:0][31:0] hpm_b;
  logic start_b, busy_b, done_b, cnt_clr_b, cfg_we_b;
  logic [1:0] alert_b, cfg_sel_b;
  logic [31:0] cnt_b, cfg_wdata_b;
  logic [7:0] cfg_addr_b;

  // dut_c signals
  logic [3:0][3:0] hpm_c;
  logic start_c, busy_c, done_c, cnt_clr_c, cfg_we_c;
  logic [1:0] alert_c, cfg_sel_c;
  logic [3:0] cnt_c, cfg_wdata_c;
  logic [7:0] cfg_addr_c;

  hpm_tree_detector #(.NUM_HPM(4), .CNT_W(32), .DEPTH(2)) dut_a (
    .clk_h(clk_h), .rst_h(rst_h), .hpm_i(hpm_a), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a), .alert_o(alert_a), .alert_cnt_o(cnt_a),
    .cnt_clr_i(cnt_clr_a), .cfg_we_i(cfg_we_a), .cfg_sel_i(cfg_sel_a),
    .cfg_addr_i(cfg_addr_a), .cfg_wdata_i(cfg_wdata_a));

  hpm_tree_detector #(.NUM_HPM(4), .CNT_W(32), .DEPTH(3)) dut_b (
    .clk_h(clk_h), .rst_h(rst_h), .hpm_i(hpm_b), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b), .alert_o(alert_b), .alert_cnt_o(cnt_b),
    .cnt_clr_i(cnt_clr_b), .cfg_we_i(cfg_we_b), .cfg_sel_i(cfg_sel_b),
    .cfg_addr_i(cfg_addr_b), .cfg_wdata_i(cfg_wdata_b));

  hpm_tree_detector #(.NUM_HPM(4), .CNT_W(4), .DEPTH(2)) dut_c (
    .clk_h(clk_h), .rst_h(rst_h), .hpm_i(hpm_c), .start_i(start_c),
    .busy_o(busy_c), .done_o(done_c), .alert_o(alert_c), .alert_cnt_o(cnt_c),
    .cnt_clr_i(cnt_clr_c), .cfg_we_i(cfg_we_c), .cfg_sel_i(cfg_sel_c),
    .cfg_addr_i(cfg_addr_c), .cfg_wdata_i(cfg_wdata_c));

  function automatic logic [3:0][31:0] mk4(input logic [31:0] h0, h1, h2, h3);
    return {h3, h2, h1, h0};
  endfunction

  // Launch one walk on dut_a and report latency, class and the count one
  // cycle after done_o. lat stays -1 if done_o never shows up.
  task automatic walk_a(input logic [3:0][31:0] h, output int lat,
                        output logic [1:0] cls, output logic [31:0] cnt);
    hpm_a = h; start_a = 1'b1; lat = -1; cls = 'x; cnt = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_h);
      if (n == 1) start_a = 1'b0;
      if (done_a === 1'b1) begin lat = n; cls = alert_a; break; end
    end
    if (lat > 0) begin @(negedge clk_h); cnt = cnt_a; end
  endtask

  // Same for dut_b; busy_wr tries to rewrite leaf 7 while the walk runs.
  task automatic walk_b(input logic [3:0][31:0] h, input logic busy_wr,
                        output int lat, output logic [1:0] cls, output logic [31:0] cnt);
    hpm_b = h; start_b = 1'b1; lat = -1; cls = 'x; cnt = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_h);
      if (n == 1) begin
        start_b = 1'b0;
        if (busy_wr) begin
          cfg_sel_b = 2'b10; cfg_addr_b = 8'd7; cfg_wdata_b = 32'd2; cfg_we_b = 1'b1;
        end
      end
      if (n == 2) cfg_we_b = 1'b0;
      if (done_b === 1'b1) begin lat = n; cls = alert_b; break; end
    end
    cfg_we_b = 1'b0;
    if (lat > 0) begin @(negedge clk_h); cnt = cnt_b; end
  endtask

  // Same for dut_c; clr raises cnt_clr_i during the done_o cycle.
  task automatic walk_c(input logic [3:0][3:0] h, input logic clr,
                        output int lat, output logic [1:0] cls, output logic [3:0] cnt);
    hpm_c = h; start_c = 1'b1; lat = -1; cls = 'x; cnt = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_h);
      if (n == 1) start_c = 1'b0;
      if (done_c === 1'b1) begin lat = n; cls = alert_c; break; end
    end
    if (lat > 0) begin
      cnt_clr_c = clr;
      @(negedge clk_h);
      cnt = cnt_c;
      cnt_clr_c = 1'b0;
    end
  endtask

  task automatic cfg_write_b(input logic [1:0] sel, input logic [7:0] addr, input logic [31:0] data);
    cfg_sel_b = sel; cfg_addr_b = addr; cfg_wdata_b = data; cfg_we_b = 1'b1;
    @(negedge clk_h);
    cfg_we_b = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_a); end
    checks++; if (alert_a !== 2'b00) begin errors++; $display("[TB] FAIL reset_alert: got %b expected 00", alert_a); end
    checks++; if (cnt_a !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt_a: got %0d expected 0", cnt_a); end
    checks++; if (cnt_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt_b: got %0d expected 0", cnt_b); end
    checks++; if (cnt_c !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt_c: got %0d expected 0", cnt_c); end
  endtask

  // Shared body for the fixed-tree table tests on dut_a.
  task automatic run_table_a(input string tag, input logic [31:0] h0[3], input logic [31:0] h1[3],
                             input logic [1:0] ecls[3], input logic [31:0] ecnt[3]);
    int lat; logic [1:0] cls; logic [31:0] cnt; exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.cls = ecls[k]; e.cnt = ecnt[k]; sb_q.push_back(e);
      walk_a(mk4(h0[k], h1[k], 32'd0, 32'd0), lat, cls, cnt);
      e = sb_q.pop_front();
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL %s_lat[%0d]: got %0d expected 3", tag, k, lat); end
      checks++; if (cls !== e.cls) begin errors++; $display("[TB] FAIL %s_cls[%0d]: got %b expected %b", tag, k, cls, e.cls); end
      checks++; if (cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s_cnt[%0d]: got %0d expected %0d", tag, k, cnt, e.cnt); end
    end
  endtask

  task automatic test_default_tree();
    logic [31:0] h0[3]   = '{32'd0, 32'd5, 32'd50};
    logic [31:0] h1[3]   = '{32'd10, 32'd20, 32'd20};
    logic [1:0]  ecls[3] = '{2'b00, 2'b10, 2'b11};
    logic [31:0] ecnt[3] = '{32'd0, 32'd1, 32'd2};
    run_table_a("default", h0, h1, ecls, ecnt);
  endtask

  task automatic test_boundary();
    logic [31:0] h0[3]   = '{32'd1000, 32'd9, 32'd10};
    logic [31:0] h1[3]   = '{32'd15, 32'd16, 32'd16};
    logic [1:0]  ecls[3] = '{2'b00, 2'b10, 2'b11};
    logic [31:0] ecnt[3] = '{32'd2, 32'd3, 32'd4};
    run_table_a("boundary", h0, h1, ecls, ecnt);
  endtask

  // hpm_i flips to a legitimate pattern right after the start, and start_i
  // is raised again during WALK and DONE; only the original snapshot counts.
  task automatic test_snapshot();
    int lat = -1; int dones = 0; logic [1:0] cls = 'x; logic [31:0] cnt = 'x; exp_t e;
    e.cls = 2'b10; e.cnt = 32'd5; sb_q.push_back(e);
    hpm_a = mk4(32'd5, 32'd20, 32'd0, 32'd0); start_a = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk_h);
      if (n == 1) hpm_a = mk4(32'd0, 32'd0, 32'd0, 32'd0);
      if (n == 2) start_a = 1'b0;
      if (n == 3) start_a = 1'b1;
      if (n == 4) start_a = 1'b0;
      if (lat > 0 && n == lat + 1) cnt = cnt_a;
      if (done_a === 1'b1) begin dones++; if (lat < 0) begin lat = n; cls = alert_a; end end
    end
    e = sb_q.pop_front();
    checks++; if (dones !== 1) begin errors++; $display("[TB] FAIL snap_dones: got %0d expected 1", dones); end
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL snap_lat: got %0d expected 3", lat); end
    checks++; if (cls !== e.cls) begin errors++; $display("[TB] FAIL snap_cls: got %b expected %b", cls, e.cls); end
    checks++; if (cnt !== e.cnt) begin errors++; $display("[TB] FAIL snap_cnt: got %0d expected %0d", cnt, e.cnt); end
  endtask

  // start_i held high: walks must be spaced exactly DEPTH+2 cycles apart.
  task automatic test_back_to_back();
    int dones = 0; int t[2] = '{-1, -1}; exp_t e;
    e.cls = 2'b11; e.cnt = 32'd0; sb_q.push_back(e);
    e.cls = 2'b00; sb_q.push_back(e);
    hpm_a = mk4(32'd50, 32'd20, 32'd0, 32'd0); start_a = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk_h);
      if (n == 4) hpm_a = mk4(32'd0, 32'd1, 32'd0, 32'd0);
      if (n == 7) start_a = 1'b0;
      if (done_a === 1'b1) begin
        if (dones < 2) t[dones] = n;
        dones++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++; if (alert_a !== e.cls) begin errors++; $display("[TB] FAIL b2b_cls[%0d]: got %b expected %b", dones, alert_a, e.cls); end
        end
      end
    end
    start_a = 1'b0;
    sb_q.delete();
    checks++; if (dones !== 2) begin errors++; $display("[TB] FAIL b2b_dones: got %0d expected 2", dones); end
    checks++; if (t[1] - t[0] !== 4) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 4", t[1] - t[0]); end
    checks++; if (cnt_a !== 32'd6) begin errors++; $display("[TB] FAIL b2b_cnt: got %0d expected 6", cnt_a); end
  endtask

  // Program a right-right-right path to leaf 7 on the DEPTH=3 instance.
  task automatic test_config();
    logic [1:0]  wsel[8]  = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0]  waddr[8] = '{8'd0, 8'd0, 8'd2, 8'd2, 8'd6, 8'd6, 8'd7, 8'd0};
    logic [31:0] wdat[8]  = '{32'd100, 32'd2, 32'd200, 32'd3, 32'd300, 32'd1, 32'd3, 32'd0};
    logic [3:0][31:0] hv[5];
    logic        bw[5]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  ecls[5]  = '{2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
    logic [31:0] ecnt[5]  = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd4};
    int lat; logic [1:0] cls; logic [31:0] cnt; exp_t e;
    hv[0] = mk4(32'd0, 32'd301, 32'd101, 32'd201);
    hv[1] = mk4(32'd0, 32'd300, 32'd101, 32'd201);
    hv[2] = hv[0];
    hv[3] = hv[0];
    hv[4] = mk4(32'd0, 32'd301, 32'd0, 32'd250);
    for (int k = 0; k < 8; k++) cfg_write_b(wsel[k], waddr[k], wdat[k]);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) cfg_write_b(2'b01, 8'd0, 32'd7);
      e.cls = ecls[k]; e.cnt = ecnt[k]; sb_q.push_back(e);
      walk_b(hv[k], bw[k], lat, cls, cnt);
      e = sb_q.pop_front();
      checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL cfg_lat[%0d]: got %0d expected 4", k, lat); end
      checks++; if (cls !== e.cls) begin errors++; $display("[TB] FAIL cfg_cls[%0d]: got %b expected %b", k, cls, e.cls); end
      checks++; if (cnt !== e.cnt) begin errors++; $display("[TB] FAIL cfg_cnt[%0d]: got %0d expected %0d", k, cnt, e.cnt); end
    end
  endtask

  // 4-bit counter: climb to 15, one more alert must not wrap, then a clear
  // during the done_o cycle wins over that cycle's increment.
  task automatic test_counter();
    int lat; logic [1:0] cls; logic [3:0] cnt; exp_t e;
    cfg_sel_c = 2'b00; cfg_addr_c = 8'd0; cfg_wdata_c = 4'd5; cfg_we_c = 1'b1;
    @(negedge clk_h);
    cfg_we_c = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      e.cls = 2'b11;
      e.cnt = (k <= 15) ? 32'(k) : (k == 16) ? 32'd15 : (k == 17) ? 32'd0 : 32'd1;
      sb_q.push_back(e);
      walk_c({4'd0, 4'd0, 4'd6, 4'd10}, (k == 17), lat, cls, cnt);
      e = sb_q.pop_front();
      checks++; if (cls !== e.cls) begin errors++; $display("[TB] FAIL cnt_cls[%0d]: got %b expected %b", k, cls, e.cls); end
      checks++; if (cnt !== e.cnt[3:0]) begin errors++; $display("[TB] FAIL cnt_val[%0d]: got %0d expected %0d", k, cnt, e.cnt); end
    end
  endtask

  // Reset in the middle of a walk: outputs drop at once, no late done_o.
  task automatic test_reset_midwalk();
    int lat; int dones = 0; logic [1:0] cls; logic [31:0] cnt; exp_t e;
    e.cls = 2'b11; e.cnt = 32'd7; sb_q.push_back(e);
    walk_a(mk4(32'd50, 32'd20, 32'd0, 32'd0), lat, cls, cnt);
    e = sb_q.pop_front();
    checks++; if (cls !== e.cls) begin errors++; $display("[TB] FAIL rstw_pre_cls: got %b expected %b", cls, e.cls); end
    checks++; if (cnt !== e.cnt) begin errors++; $display("[TB] FAIL rstw_pre_cnt: got %0d expected %0d", cnt, e.cnt); end
    hpm_a = mk4(32'd50, 32'd20, 32'd0, 32'd0); start_a = 1'b1;
    @(negedge clk_h); start_a = 1'b0;
    @(negedge clk_h);
    #2 rst_h = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL rstw_busy: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL rstw_done: got %b expected 0", done_a); end
    checks++; if (alert_a !== 2'b00) begin errors++; $display("[TB] FAIL rstw_alert: got %b expected 00", alert_a); end
    checks++; if (cnt_a !== 32'd0) begin errors++; $display("[TB] FAIL rstw_cnt: got %0d expected 0", cnt_a); end
    @(negedge clk_h); rst_h = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_h);
      if (done_a === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("[TB] FAIL rstw_late_done: got %0d expected 0", dones); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_h = 1'b1;
    hpm_a = '0; start_a = 0; cnt_clr_a = 0; cfg_we_a = 0; cfg_sel_a = 0; cfg_addr_a = 0; cfg_wdata_a = 0;
    hpm_b = '0; start_b = 0; cnt_clr_b = 0; cfg_we_b = 0; cfg_sel_b = 0; cfg_addr_b = 0; cfg_wdata_b = 0;
    hpm_c = '0; start_c = 0; cnt_clr_c = 0; cfg_we_c = 0; cfg_sel_c = 0; cfg_addr_c = 0; cfg_wdata_c = 0;
    repeat (3) @(negedge clk_h);
    rst_h = 1'b0;
    @(negedge clk_h);
    test_reset();
    test_default_tree();
    test_boundary();
    test_snapshot();
    test_back_to_back();
    test_config();
    test_counter();
    test_reset_midwalk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpm_tree_detector.md
# hpm_tree_detector

Parametrised successor to the fixed two-level HPM attack detector. Runs a runtime-programmable binary decision tree of configurable depth over a snapshot of NUM_HPM hardware performance counters, one tree level per cycle. Classifies each window as legitimate, stack overflow or heap overflow, and keeps a saturating alert count. Sits between the core HPM counter bank and the Diwall alert/response logic.

## Interface
Parameters:
- NUM_HPM, 4, number of HPM counter inputs (≥2)
- CNT_W, 32, counter, threshold and alert-count width
- DEPTH, 2, tree depth; nodes = 2^DEPTH−1, leaves = 2^DEPTH (1..4)
- FSEL_W, $clog2(NUM_HPM), feature-select width

Ports:
- clk_h  in  1  clock
- rst_h  in  1  reset, asynchronous, active-high
- hpm_i  in  [NUM_HPM][CNT_W]  counter values
- start_i  in  1  request a classification (was enableD)
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse, result valid
- alert_o  out  2  class of last decision, held until next done_o
- alert_cnt_o  out  CNT_W  count of non-LEG decisions
- cnt_clr_i  in  1  synchronous clear of alert_cnt_o
- cfg_we_i  in  1  config write strobe
- cfg_sel_i  in  2  00 node threshold, 01 node feature, 10 leaf class, 11 reserved
- cfg_addr_i  in  8  node or leaf index
- cfg_wdata_i  in  CNT_W  write data (LSBs used for feature/class)

## Operation
- States: IDLE, WALK, DONE.
- IDLE: start_i=1 → latch all hpm_i into snapshot, node←0, level←0, busy_o←1, go WALK. start_i while busy is ignored, not queued.
- WALK: f=feat[node]; if snap[f] ≤ thr[node] (unsigned) node←2·node+1 else node←2·node+2; level++. After DEPTH evaluations, leaf = node−(2^DEPTH−1); go DONE.
- DONE: alert_o←leaf_class[leaf], done_o=1 for this cycle, busy_o←0, return IDLE. start_i is sampled again only in IDLE (next cycle).
- Classes: 00 LEG, 01 reserved, 10 stack overflow, 11 heap overflow.
- alert_cnt: +1 at DONE if class≠LEG; saturates at 2^CNT_W−1. cnt_clr_i has priority over a same-cycle increment (increment lost).
- Config: writes accepted only when busy_o=0; writes while busy or with out-of-range addr/sel=11 are dropped silently. Feature index ≥NUM_HPM written is clamped to NUM_HPM−1.
- Reset values: alert_o=00, done_o=0, busy_o=0, alert_cnt_o=0, state IDLE. Config defaults (DEPTH=2): node0 feat 1 thr 15; node1 feat 0 thr 2^CNT_W−1; node2 feat 0 thr 9; leaves 0,1 = LEG, leaf2 = stack overflow, leaf3 = heap overflow — reproduces the legacy detector. For other DEPTH: all thresholds max, all leaves LEG.
- Reset mid-walk: abort immediately, no done_o, counter cleared.

## Timing
- start_i accepted at edge T → done_o high during cycle T+DEPTH+1; busy_o high T+1..T+DEPTH+1 inclusive (falls at the edge ending DONE).
- Back-to-back: min start-to-start spacing DEPTH+2 cycles.
- hpm_i changes after T do not affect the decision (snapshot).
- Config write at edge E affects any walk starting at E+1 or later.

## Structure
- Package hpm_det_pkg: class enum (LEG, RSVD, SBO, HBO), cfg_sel enum, state enum, default threshold constants (15, 9).
- Sub-module hpm_det_cfg_regs: threshold/feature/leaf-class register file, write gating and clamping, reset defaults. Top holds FSM, snapshot, feature mux/compare, counter.

## Test plan
- Defaults, DEPTH=2: hpm[1]=10 start → done_o at T+3, alert_o=00, count 0; hpm[1]=20,hpm[0]=5 → 10, count 1; hpm[1]=20,hpm[0]=50 → 11, count 2.
- Boundary: hpm[1]=15 → 00; hpm[1]=16,hpm[0]=9 → 10; hpm[0]=10 → 11.
- Snapshot/busy: change hpm_i and pulse start_i during WALK → result from original snapshot, second start ignored, exactly one done_o.
- Config: DEPTH=3, program node thresholds/features and leaf7=11 while idle → matching input reaches leaf7 at T+4; write during busy → no effect.
- Counter: preload via CNT_W=4 to 15, one more alert → stays 15; cnt_clr_i with same-cycle alert → 0.
- Reset asserted mid-WALK → outputs to reset values asynchronously, no done_o after release.
